alu_serial_ctrl: RTL and testbench

//  Bit-serial sequencer for the 1-bit ALU slice (M, a, b, c -> out, next).

---
 rtl/alu_serial_ctrl_pkg.sv | 42 ++++
 rtl/alu_serial_ctrl_slice.sv | 33 +++
 rtl/alu_serial_ctrl.sv | 132 +++++++++++++
 tb/tb_alu_serial_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: opcodes, slice
// function selects (one-hot M) and FSM state encodings.
package alu_serial_ctrl_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADC  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    localparam logic [7:0] M_NONE  = 8'b0000_0000;
    localparam logic [7:0] M_ARITH = 8'b0000_0001;
    localparam logic [7:0] M_AND   = 8'b0000_0010;
    localparam logic [7:0] M_OR    = 8'b0000_0100;
    localparam logic [7:0] M_XOR   = 8'b0000_1000;
    localparam logic [7:0] M_XNOR  = 8'b0001_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_XNOR;
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ADC);
    endfunction

    function automatic logic [7:0] op_to_m(input logic [2:0] op);
        case (op)
            OP_ADD, OP_ADC: return M_ARITH;
            OP_AND:         return M_AND;
            OP_OR:          return M_OR;
            OP_XOR:         return M_XOR;
            OP_XNOR:        return M_XNOR;
            default:        return M_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_slice.sv
// 1-bit ALU slice: one-hot function select M, operand bits a/b, carry-in c.
// Any select other than a single legal one-hot code yields out=0, next=0.
module alu_serial_ctrl_slice
    import alu_serial_ctrl_pkg::*;
(
    input  logic [7:0] M,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       out,
    output logic       next
);

    always_comb begin
        out  = 1'b0;
        next = 1'b0;
        case (M)
            M_ARITH: begin
                out  = a ^ b ^ c;
                next = (a & b) | (a & c) | (b & c);
            end
            M_AND:   out = a & b;
            M_OR:    out = a | b;
            M_XOR:   out = a ^ b;
            M_XNOR:  out = ~(a ^ b);
            default: begin
                out  = 1'b0;
                next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: feeds the shared 1-bit ALU slice LSB-first, recirculates
// the carry and assembles a WIDTH-bit result committed in one step.
module alu_serial_ctrl
    import alu_serial_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             err
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [2:0]       op_q,     op_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic             err_q,    err_d;

    logic [7:0]       slice_m;
    logic             slice_out;
    logic             slice_next;

    assign slice_m = (state_q == ST_RUN) ? op_to_m(op_q) : M_NONE;

    alu_serial_ctrl_slice u_slice (
        .M    (slice_m),
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .c    (carry_q),
        .out  (slice_out),
        .next (slice_next)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        result_d = result_q;
        count_d  = count_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_is_legal(op)) begin
                        a_sr_d  = opa;
                        b_sr_d  = opb;
                        carry_d = (op == OP_ADC) ? cin : 1'b0;
                        count_d = '0;
                        op_d    = op;
                        state_d = ST_RUN;
                    end else begin
                        result_d = '0;
                        cout_d   = 1'b0;
                        err_d    = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                res_sr_d = {slice_out, res_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = op_is_arith(op_q) ? slice_next : 1'b0;
                count_d  = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    result_d = {slice_out, res_sr_q[WIDTH-1:1]};
                    cout_d   = op_is_arith(op_q) ? slice_next : 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            result_q <= '0;
            count_q  <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            result_q <= result_d;
            count_q  <= count_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl (WIDTH=8): cycle-accurate transaction model plus
// directed operations with hand-computed results.
module tb_alu_serial_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic         cin;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .cin    (cin),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted op occupies the block for WIDTH+1 cycles
    // (1 for an illegal op); outputs appear in the final cycle of that window.
    int           m_left;
    logic [W-1:0] m_pres, m_res;
    logic         m_pcout, m_cout, m_perr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_res  = '0;
            m_cout = 1'b0;
            m_perr = 1'b0;
        end else begin
            if (m_left == 0) begin
                if (start) begin
                    if (op > 3'd5) begin
                        m_pres  = '0;
                        m_pcout = 1'b0;
                        m_perr  = 1'b1;
                        m_left  = 1;
                    end else begin
                        logic [W:0] sum;
                        m_perr  = 1'b0;
                        m_pcout = 1'b0;
                        case (op)
                            3'd0: begin sum = opa + opb;       m_pres = sum[W-1:0]; m_pcout = sum[W]; end
                            3'd1: begin sum = opa + opb + cin; m_pres = sum[W-1:0]; m_pcout = sum[W]; end
                            3'd2: m_pres = opa & opb;
                            3'd3: m_pres = opa | opb;
                            3'd4: m_pres = opa ^ opb;
                            default: m_pres = ~(opa ^ opb);
                        endcase
                        m_left = W + 1;
                    end
                end
            end else begin
                m_left = m_left - 1;
            end
            if (m_left == 1) begin
                m_res  = m_pres;
                m_cout = m_pcout;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("busy",   32'(busy),   32'(m_left != 0));
        chk("done",   32'(done),   32'(m_left == 1));
        chk("err",    32'(err),    32'((m_left == 1) && m_perr));
        chk("result", 32'(result), 32'(m_res));
        chk("cout",   32'(cout),   32'(m_cout));
    end

    // inj: RUN cycle at which a competing start is pulsed; 100 = pulse in DONE cycle.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic [W-1:0] er, input logic ec, input logic ee,
                         input int elat, input int inj);
        int lat;
        int bcnt;
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b; cin = ci;
        @(posedge clk);
        #2;
        start = 1'b0;
        opa = W'($urandom); opb = W'($urandom); op = 3'($urandom_range(0, 7)); cin = 1'($urandom);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
            if (lat == inj && !done) begin
                start = 1'b1; op = 3'd2; opa = 8'h11; opb = 8'h22; cin = 1'b1;
            end
        end
        chk("latency",    32'(lat),    32'(elat));
        chk("lit_result", 32'(result), 32'(er));
        chk("lit_cout",   32'(cout),   32'(ec));
        chk("lit_err",    32'(err),    32'(ee));
        if (inj == 100) begin
            start = 1'b1; op = 3'd0; opa = 8'h01; opb = 8'h01;
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        if (busy) bcnt++;
        chk("busy_cycles", 32'(bcnt),   32'(elat + 1));
        chk("done_low",    32'(done),   32'd0);
        chk("hold_result", 32'(result), 32'(er));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; cin = 1'b0; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout",   32'(cout),   32'd0);
        chk("rst_err",    32'(err),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'd0, 8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 1'b0, 8, -1);
        do_op(3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8, -1);
        do_op(3'd1, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 8, -1);
        do_op(3'd1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 8, -1);
        do_op(3'd0, 8'hFF, 8'hFF, 1'b1, 8'hFE, 1'b1, 1'b0, 8, -1);
        do_op(3'd2, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 8, -1);
        do_op(3'd3, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0, 8, -1);
        do_op(3'd4, 8'hAA, 8'h0F, 1'b1, 8'hA5, 1'b0, 1'b0, 8, -1);
        do_op(3'd5, 8'hAA, 8'h0F, 1'b1, 8'h5A, 1'b0, 1'b0, 8, -1);
        do_op(3'd6, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b1, 0, -1);
        do_op(3'd7, 8'h56, 8'h78, 1'b1, 8'h00, 1'b0, 1'b1, 0, -1);
        do_op(3'd0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 8, 3);
        do_op(3'd3, 8'h81, 8'h18, 1'b0, 8'h99, 1'b0, 1'b0, 8, 100);

        // Abort in the middle of RUN.
        @(negedge clk);
        start = 1'b1; op = 3'd0; opa = 8'h55; opb = 8'h66; cin = 1'b0;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_done",   32'(done),   32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout",   32'(cout),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'd0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 8, -1);

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
